// File: rtl/regbank_wb_ctrl.sv
// Purpose: write-back arbiter and pending-write scoreboard for the 32x32 register bank.
// Latency: a vld&&rdy transfer in cycle N drives ENA_WRITE/WRITE_REG/WRITE_DATA in N+1; stall is combinational.
// Backpressure: the requester losing arbitration sees rdy=0 and holds its request; nothing is buffered here.
//
// Optional build macro RR_ARB_EN: contention is granted alternately instead of load-first.
// Ports:
//   CLK, aRSTn                      clock (rising edge) and async active-low reset
//   alu_vld/alu_rdy/alu_reg/alu_data ALU write-back request
//   ld_vld/ld_rdy/ld_reg/ld_data     load-unit write-back request
//   dec_set_vld/dec_set_reg          decode marks a destination register as pending
//   rs1, rs2 -> stall                decode read ports and RAW hazard flag
//   ENA_WRITE/WRITE_REG/WRITE_DATA   registered register-bank write port
//   pending                          scoreboard vector (debug)
module regbank_wb_ctrl #(
    parameter int SIZE = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            CLK,
    input  logic            aRSTn,
    input  logic            alu_vld,
    output logic            alu_rdy,
    input  logic [AW-1:0]   alu_reg,
    input  logic [SIZE-1:0] alu_data,
    input  logic            ld_vld,
    output logic            ld_rdy,
    input  logic [AW-1:0]   ld_reg,
    input  logic [SIZE-1:0] ld_data,
    input  logic            dec_set_vld,
    input  logic [AW-1:0]   dec_set_reg,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            stall,
    output logic            ENA_WRITE,
    output logic [AW-1:0]   WRITE_REG,
    output logic [SIZE-1:0] WRITE_DATA,
    output logic [NREG-1:0] pending
);

    logic            alu_gnt;
    logic            ld_gnt;
    logic            xfer_vld;
    logic [AW-1:0]   xfer_reg;
    logic [SIZE-1:0] xfer_data;

    logic            ena_q,   ena_d;
    logic [AW-1:0]   wreg_q,  wreg_d;
    logic [SIZE-1:0] wdata_q, wdata_d;
    logic [NREG-1:0] pend_q,  pend_d;

`ifdef RR_ARB_EN
    // ptr_q=1 means the load unit wins the next contended cycle; reset favours the ALU.
    logic ptr_q, ptr_d;

    always_comb begin
        ld_gnt  = 1'b0;
        alu_gnt = 1'b0;
        if (alu_vld && ld_vld) begin
            ld_gnt  = ptr_q;
            alu_gnt = ~ptr_q;
        end else begin
            ld_gnt  = ld_vld;
            alu_gnt = alu_vld;
        end
    end

    // Any grant hands priority to the other requester.
    always_comb begin
        ptr_d = ptr_q;
        if (alu_gnt) begin
            ptr_d = 1'b1;
        end else if (ld_gnt) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge aRSTn) begin
        if (!aRSTn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Load has fixed priority; the ALU may wait indefinitely under back-to-back loads.
    always_comb begin
        ld_gnt  = ld_vld;
        alu_gnt = alu_vld & ~ld_vld;
    end
`endif

    assign alu_rdy = alu_gnt;
    assign ld_rdy  = ld_gnt;

    assign xfer_vld  = alu_gnt | ld_gnt;
    assign xfer_reg  = ld_gnt ? ld_reg  : alu_reg;
    assign xfer_data = ld_gnt ? ld_data : alu_data;

    // Writes to r0 are accepted and dropped; the write port keeps its last reg/data.
    always_comb begin
        ena_d   = xfer_vld && (xfer_reg != '0);
        wreg_d  = ena_d ? xfer_reg  : wreg_q;
        wdata_d = ena_d ? xfer_data : wdata_q;
    end

    // Clear the register committing this cycle first so a same-edge set survives.
    always_comb begin
        pend_d = pend_q;
        if (ena_q) begin
            pend_d[wreg_q] = 1'b0;
        end
        if (dec_set_vld) begin
            pend_d[dec_set_reg] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge aRSTn) begin
        if (!aRSTn) begin
            ena_q   <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
        end else begin
            ena_q   <= ena_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    // No bypass: a register whose write is on the port this cycle still stalls.
    assign stall = ((rs1 != '0) && pend_q[rs1]) || ((rs2 != '0) && pend_q[rs2]);

    assign ENA_WRITE  = ena_q;
    assign WRITE_REG  = wreg_q;
    assign WRITE_DATA = wdata_q;
    assign pending    = pend_q;

endmodule

// File: doc/regbank_wb_ctrl.md
Name: regbank_wb_ctrl

Overview:
- Write-back controller and scoreboard for the 32x32 register bank.
- Arbitrates two write-back requesters (ALU result, load unit) onto the bank's single write port: ENA_WRITE / WRITE_REG / WRITE_DATA.
- Tracks per-register pending writes and flags read-after-write hazards on both read ports to the decode stage.
- Sits between the execute/memory stages and the register bank.

Parameters:
- SIZE, 32, data width of write-back data.
- NREG, 32, number of architectural registers (one pending bit each).
- AW, 5, register index width.

Ports:
- CLK  input  1  clock, rising edge.
- aRSTn  input  1  asynchronous, active-low reset.
- alu_vld  input  1  ALU write-back request valid.
- alu_rdy  output  1  ALU request accepted this cycle (combinational).
- alu_reg  input  AW  ALU destination register.
- alu_data  input  SIZE  ALU result.
- ld_vld  input  1  load write-back request valid.
- ld_rdy  output  1  load request accepted this cycle (combinational).
- ld_reg  input  AW  load destination register.
- ld_data  input  SIZE  load data.
- dec_set_vld  input  1  decode issues an instruction that will write dec_set_reg.
- dec_set_reg  input  AW  destination register of the issued instruction.
- rs1  input  AW  decode read-port-1 register index.
- rs2  input  AW  decode read-port-2 register index.
- stall  output  1  RAW hazard on rs1 or rs2 (combinational).
- ENA_WRITE  output  1  register bank write enable (registered).
- WRITE_REG  output  AW  register bank write index (registered).
- WRITE_DATA  output  SIZE  register bank write data (registered).
- pending  output  NREG  scoreboard vector, for debug.

Behaviour:
- Reset (aRSTn low, asynchronous): ENA_WRITE=0, WRITE_REG=0, WRITE_DATA=0, pending=0, round-robin pointer=ALU. Reset mid-transfer discards any request in flight; no write is issued after release until a new handshake occurs.
- Handshake: a transfer occurs when vld && rdy. At most one grant per cycle. The rdy of the non-granted requester is 0. A requester must hold vld, reg and data stable until rdy is seen.
- Arbitration: only one requester valid -> it is granted. Both valid -> load wins (fixed priority) unless RR_ARB_EN is defined.
- Latency: transfer in cycle N -> ENA_WRITE=1 with the captured reg/data in cycle N+1; the bank commits at the end of N+1. No transfer -> ENA_WRITE=0 in N+1; WRITE_REG/WRITE_DATA hold their last values.
- Register 0:
  - A transfer to reg 0 is accepted (rdy=1) but produces ENA_WRITE=0.
  - dec_set_vld with reg 0 is ignored.
  - pending[0] is always 0.
- Scoreboard:
  - pending[dec_set_reg] is set at the clock edge when dec_set_vld=1.
  - pending[WRITE_REG] is cleared at the clock edge when ENA_WRITE=1.
  - Same register set and cleared at the same edge -> set wins (newer producer outstanding).
  - Setting an already-set bit is legal and leaves it set; no counting of multiple producers.
- Hazard: stall = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]). It is purely combinational from the current pending state. There is no bypass, so a register being written this cycle still stalls until the cycle after ENA_WRITE.
- Throughput: one write per cycle sustained. A requester losing arbitration waits with no buffering inside the block.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: both valid -> grant goes to the requester the pointer selects. After any grant, the pointer moves to the other requester. Contention is therefore granted strictly alternately, and neither requester waits more than one cycle.
- Undefined: fixed priority, load over ALU, pointer logic absent. Under sustained load traffic the ALU may starve; this is acceptable for the in-order pipeline.

Test Plan:
- Reset: assert aRSTn=0 mid-stream with alu_vld=1 -> ENA_WRITE=0, pending=0 immediately; after release with no vld, ENA_WRITE stays 0.
- Single write: alu_vld=1, alu_reg=5, alu_data=0xDEADBEEF in cycle N -> alu_rdy=1 in N; ENA_WRITE=1, WRITE_REG=5, WRITE_DATA=0xDEADBEEF in N+1; 0 in N+2.
- Contention: ld(reg 3, 0x11) and alu(reg 4, 0x22) both held valid for 2 cycles:
  - without RR_ARB_EN -> writes reg 3 then reg 4;
  - with RR_ARB_EN from reset -> reg 4 then reg 3.
- Register 0: alu_vld to reg 0 with data 0xFFFFFFFF -> alu_rdy=1, ENA_WRITE stays 0; dec_set_vld reg 0 -> pending[0]=0; rs1=0 -> stall=0.
- Scoreboard: dec_set reg 7 -> pending[7]=1, rs2=7 gives stall=1. Ld write-back reg 7 -> pending[7] clears at the ENA_WRITE edge and stall drops the following cycle. Repeat with dec_set reg 7 on that same edge -> pending[7] remains 1.
- Back-to-back: alu writes regs 1,2,3 in consecutive cycles -> ENA_WRITE high 3 consecutive cycles with WRITE_REG 1,2,3.
